// File: rtl/led_matrix_scan.sv
// Time-multiplexed ANODES x CATHODES LED matrix driver with per-slot blanking, global PWM and double-buffered frames.
// Optional feature macro: LED_SCAN_SKIP_EN (dark slots collapse to a single cycle).
module led_matrix_scan #(
  parameter int unsigned ANODES   = 4,
  parameter int unsigned CATHODES = 4,
  parameter int unsigned BLANK    = 4,
  parameter int unsigned PWM_BITS = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ANODES*CATHODES-1:0]   ledbits,
  input  logic [PWM_BITS-1:0]          brightness,
  input  logic                         load,
  output logic [ANODES-1:0]            aled,
  output logic [CATHODES-1:0]          kled_tri,
  output logic                         frame_start
);

  localparam int unsigned N  = ANODES * CATHODES;
  localparam int unsigned S  = BLANK + (1 << PWM_BITS);
  localparam int unsigned CW = $clog2(S);
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = (ANODES > 1) ? $clog2(ANODES) : 1;
  localparam int unsigned KW = (CATHODES > 1) ? $clog2(CATHODES) : 1;

  logic [CW-1:0]       c;
  logic [SW-1:0]       s;
  logic [AW-1:0]       a;
  logic [KW-1:0]       k;
  logic [N-1:0]        act_bits;
  logic [N-1:0]        pend_bits;
  logic [PWM_BITS-1:0] act_br;
  logic [PWM_BITS-1:0] pend_br;

  logic                boundary_c;
  logic                slot_end_c;
  logic                lit_c;
  logic [CW-1:0]       pwm_off_c;
`ifdef LED_SCAN_SKIP_EN
  logic [N-1:0]        eff_bits_c;
`endif

  // Slot timing and drive decision at the current (s, c)
  always_comb begin
    boundary_c = (s == '0) && (c == '0);
    pwm_off_c  = c - CW'(BLANK);
    lit_c      = act_bits[s] && (c >= CW'(BLANK)) && (pwm_off_c < CW'(act_br));
`ifdef LED_SCAN_SKIP_EN
    // On the boundary the buffer being promoted decides slot 0's length
    eff_bits_c = boundary_c ? pend_bits : act_bits;
    slot_end_c = (c == CW'(S - 1)) || !eff_bits_c[s];
`else
    slot_end_c = (c == CW'(S - 1));
`endif
  end

  // Cycle, slot, anode and cathode counters; a/k track s without a divider
  always_ff @(posedge clk) begin
    if (reset) begin
      c <= '0;
      s <= '0;
      a <= '0;
      k <= '0;
    end else if (slot_end_c) begin
      c <= '0;
      if (s == SW'(N - 1)) begin
        s <= '0;
        a <= '0;
        k <= '0;
      end else begin
        s <= s + 1'b1;
        if (a == AW'(ANODES - 1)) begin
          a <= '0;
          k <= k + 1'b1;
        end else begin
          a <= a + 1'b1;
        end
      end
    end else begin
      c <= c + 1'b1;
    end
  end

  // Pending buffer takes loads; active buffer swaps only on the frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_bits <= '0;
      pend_br   <= '1;
      act_bits  <= '0;
      act_br    <= '1;
    end else begin
      if (load) begin
        pend_bits <= ledbits;
        pend_br   <= brightness;
      end
      if (boundary_c) begin
        act_bits <= pend_bits;
        act_br   <= pend_br;
      end
    end
  end

  // Registered pin drive; anode and cathode always switch together
  always_ff @(posedge clk) begin
    if (reset) begin
      aled        <= '1;
      kled_tri    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary_c;
      aled        <= lit_c ? ~(ANODES'(1) << a) : '1;
      kled_tri    <= lit_c ? (CATHODES'(1) << k) : '0;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Randomised and directed bench for led_matrix_scan against a frame-level reference model.
module tb_led_matrix_scan;

  localparam int unsigned A  = 4;
  localparam int unsigned K  = 4;
  localparam int unsigned BL = 4;
  localparam int unsigned PB = 5;
  localparam int unsigned N  = A * K;
  localparam int unsigned S  = BL + (1 << PB);

`ifdef LED_SCAN_SKIP_EN
  localparam int FL0      = 16;
  localparam int FL_0001  = 51;
  localparam int OFF_8000 = 20;
  localparam int FL_FF00  = 296;
`else
  localparam int FL0      = 576;
  localparam int FL_0001  = 576;
  localparam int OFF_8000 = 545;
  localparam int FL_FF00  = 576;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  ledbits;
  logic [PB-1:0] brightness;
  logic          load;
  logic [A-1:0]  aled;
  logic [K-1:0]  kled_tri;
  logic          frame_start;

  int total = 0;
  int bad   = 0;

  led_matrix_scan #(.ANODES(A), .CATHODES(K), .BLANK(BL), .PWM_BITS(PB)) dut (
    .clk(clk), .reset(reset), .ledbits(ledbits), .brightness(brightness), .load(load),
    .aled(aled), .kled_tri(kled_tri), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-relative time, slot lengths summed from the active buffer
  function automatic int slot_len(input logic [N-1:0] b, input int i);
`ifdef LED_SCAN_SKIP_EN
    return b[i] ? int'(S) : 1;
`else
    return int'(S) + 0 * int'(b[i]);
`endif
  endfunction

  function automatic int frame_len(input logic [N-1:0] b);
    int sum = 0;
    for (int i = 0; i < int'(N); i++) sum += slot_len(b, i);
    return sum;
  endfunction

  logic [N-1:0]  m_pend, m_act;
  logic [PB-1:0] m_pbr, m_abr;
  int            m_t = 0;
  int            m_len = 0;
  logic [A-1:0]  e_aled;
  logic [K-1:0]  e_k;
  logic          e_fs;
  bit            m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pend = '0; m_act = '0; m_pbr = '1; m_abr = '1;
      m_t = 0; m_len = frame_len('0);
      e_aled = '1; e_k = '0; e_fs = 1'b0;
      m_valid = 1'b1;
    end else begin
      int start, slot, off;
      bit found, lit;
      e_fs = (m_t == 0);
      if (m_t == 0) begin
        m_act = m_pend; m_abr = m_pbr; m_len = frame_len(m_act);
      end
      start = 0; slot = 0; off = 0; found = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        if (!found && m_t < start + slot_len(m_act, i)) begin
          found = 1'b1; slot = i; off = m_t - start;
        end
        start += slot_len(m_act, i);
      end
      lit = m_act[slot] && off >= int'(BL) && (off - int'(BL)) < int'(m_abr);
      e_aled = lit ? ~(A'(1) << (slot % int'(A))) : '1;
      e_k    = lit ? (K'(1) << (slot / int'(A))) : '0;
      if (load) begin m_pend = ledbits; m_pbr = brightness; end
      m_t++;
      if (m_t >= m_len) m_t = 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("aled", int'(aled), int'(e_aled));
      chk("kled_tri", int'(kled_tri), int'(e_k));
      chk("frame_start", int'(frame_start), int'(e_fs));
    end
  end

  task automatic do_load(input logic [N-1:0] b, input logic [PB-1:0] br);
    ledbits = b; brightness = br; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 3000);
    chk("fs_wait", int'(frame_start), 1);
  endtask

  task automatic wait_t(input int t);
    int n = 0;
    while (m_t != t && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t_wait", m_t, t);
  endtask

  // Called on a frame_start sample; runs to the next frame_start
  task automatic measure(output int len, output int nlit, output int first_off,
                         output int fa, output int fk);
    int idx = 0;
    bit done = 1'b0;
    nlit = 0; first_off = -1; fa = 15; fk = 0;
    while (!done) begin
      if (kled_tri != '0) begin
        if (first_off < 0) begin first_off = idx + 1; fa = int'(aled); fk = int'(kled_tri); end
        nlit++;
      end
      @(negedge clk);
      idx++;
      if (frame_start || idx >= 3000) done = 1'b1;
    end
    len = idx;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int n, len, nlit, off, fa, fk;
    reset = 1'b1; load = 1'b0; ledbits = '0; brightness = '0;
    repeat (3) @(negedge clk);
    chk("rst_aled", int'(aled), 15);
    chk("rst_kled", int'(kled_tri), 0);
    chk("rst_fs", int'(frame_start), 0);
    reset = 1'b0;
    wait_fs(n);
    chk("fs_after_release", n, 1);
    wait_fs(n);
    chk("idle_frame_len", n, FL0);

    repeat (10) @(negedge clk);
    do_load(16'h0001, 5'd31);
    wait_fs(n);
    measure(len, nlit, off, fa, fk);
    chk("f0001_len", len, FL_0001);
    chk("f0001_lit", nlit, 31);
    chk("f0001_off", off, 5);
    chk("f0001_aled", fa, 4'b1110);
    chk("f0001_kled", fk, 4'b0001);

    repeat (3) @(negedge clk);
    do_load(16'h8000, 5'd1);
    wait_fs(n);
    measure(len, nlit, off, fa, fk);
    chk("f8000_lit", nlit, 1);
    chk("f8000_off", off, OFF_8000);
    chk("f8000_aled", fa, 4'b0111);
    chk("f8000_kled", fk, 4'b1000);

    repeat (7) @(negedge clk);
    do_load(16'h00FF, 5'd31);
    repeat (5) @(negedge clk);
    do_load(16'hFF00, 5'd31);
    wait_t(0);
    do_load(16'hAAAA, 5'd31);
    chk("fs_on_boundary_load", int'(frame_start), 1);
    measure(len, nlit, off, fa, fk);
    chk("fFF00_len", len, FL_FF00);
    chk("fFF00_lit", nlit, 248);
    chk("fFF00_aled", fa, 4'b1110);
    chk("fFF00_kled", fk, 4'b0100);
    measure(len, nlit, off, fa, fk);
    chk("fAAAA_lit", nlit, 248);
    chk("fAAAA_aled", fa, 4'b1101);
    chk("fAAAA_kled", fk, 4'b0001);

    do_load(16'hFFFF, 5'd31);
    wait_fs(n);
    wait_t(7 * int'(S) + 20);
    chk("pre_reset_kled", int'(kled_tri), 4'b0010);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_aled", int'(aled), 15);
    chk("midrst_kled", int'(kled_tri), 0);
    chk("midrst_fs", int'(frame_start), 0);
    reset = 1'b0;
    wait_fs(n);
    chk("fs_after_midrst", n, 1);
    measure(len, nlit, off, fa, fk);
    chk("post_rst_lit", nlit, 0);
    chk("post_rst_len", len, FL0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset = (cyc >= 2500 && cyc < 2502);
      load = ($urandom_range(0, 99) < 2);
      if (load) begin
        ledbits = N'($urandom);
        brightness = PB'($urandom);
      end
      @(negedge clk);
    end
    load = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
